// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of a fifomem among NREQ
// valid/ready producers; each grant lasts up to MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [WIDTH-1:0]          fifo_wr_data,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [CW-1:0]   beat_q,  beat_d;

    logic            pick_vld;
    logic [IW-1:0]   pick;
    logic            sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic            in_grant;
    logic            xfer;

    // Two passes: indices above last_q first, then wrap around to 0..last_q.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!pick_vld && req_valid[j] && (IW'(j) > last_q)) begin
                pick_vld = 1'b1;
                pick     = IW'(j);
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!pick_vld && req_valid[j] && (IW'(j) <= last_q)) begin
                pick_vld = 1'b1;
                pick     = IW'(j);
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (owner_q == IW'(k)) begin
                sel_valid = req_valid[k];
                sel_data  = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_grant = (state_q == GRANT);
    assign xfer     = in_grant && sel_valid && !fifo_full;

    always_comb begin
        req_ready = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            req_ready[k] = in_grant && !fifo_full && (owner_q == IW'(k));
        end
    end

    assign fifo_wr_en   = xfer;
    assign fifo_wr_data = in_grant ? sel_data : '0;
    assign grant_id     = owner_q;
    assign busy         = in_grant;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    owner_d = pick;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                // A dropped valid releases the grant even while the fifo is full.
                if (!sel_valid) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (!fifo_full) begin
                    if (beat_q == CW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end else begin
                        beat_d = beat_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter driving a behavioural 8-deep fifo.
module tb_fifo_wr_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int DEPTH = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [WIDTH-1:0]      fifo_wr_data;
    logic [1:0]            grant_id;
    logic                  busy;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0]  src [NREQ][$];
    logic [5:0]  exp_q [$];
    logic [3:0]  rd_q [$];
    logic [NREQ-1:0] acc = '0;
    logic [31:0] trace = '0;
    logic        trace_en = 1'b0;
    logic        rd_chk = 1'b0;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [2:0]  wptr = '0;
    logic [2:0]  rptr = '0;
    logic [3:0]  cnt = '0;
    logic        force_full = 1'b0;
    logic        drain = 1'b1;
    logic        rd_en = 1'b0;
    logic        rd_fire;
    logic        wr_fire;

    always #25 clk = ~clk;

    assign fifo_full = (cnt == 4'(DEPTH)) || force_full;
    assign rd_fire   = (cnt != 4'd0) && (drain || rd_en);
    assign wr_fire   = fifo_wr_en && (cnt != 4'(DEPTH));

    always @(posedge clk) begin
        if (wr_fire) begin
            mem[wptr] <= fifo_wr_data;
            wptr      <= wptr + 3'd1;
        end
        if (rd_fire) rptr <= rptr + 3'd1;
        cnt <= cnt + 4'(wr_fire) - 4'(rd_fire);
    end

    fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on every write and fifo read.
    always @(negedge clk) begin
        logic [5:0] e;
        logic [3:0] r;
        acc = req_ready & req_valid;
        if (reset) begin
            vectors++;
            if ($countones(req_ready) > 1 || (fifo_wr_en && fifo_full)) begin
                miscompares++;
                $display("FAIL handshake_rule: ready=%b wr_en=%b full=%b, need <=1 ready and no write when full",
                         req_ready, fifo_wr_en, fifo_full);
            end
        end
        if (fifo_wr_en) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got owner %0d data 0x%0h, expected no write", grant_id, fifo_wr_data);
            end else begin
                e = exp_q.pop_front();
                check("write_owner_data", 32'({grant_id, fifo_wr_data}), 32'(e));
            end
        end
        if (rd_fire && rd_chk) begin
            if (rd_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_read: got 0x%0h, expected no read", mem[rptr]);
            end else begin
                r = rd_q.pop_front();
                check("fifo_readout", 32'(mem[rptr]), 32'(r));
            end
        end
        if (trace_en) trace = {trace[30:0], fifo_wr_en};
    end

    function automatic void apply();
        for (int i = 0; i < NREQ; i++) begin
            if (src[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_data[i*WIDTH +: WIDTH] = src[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*WIDTH +: WIDTH] = '0;
            end
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (acc[i] && src[i].size() > 0) void'(src[i].pop_front());
        apply();
    endtask

    task automatic load(input int r, input logic [3:0] d, input logic exp_it);
        src[r].push_back(d);
        if (exp_it) exp_q.push_back({2'(r), d});
    endtask

    task automatic reset_dut();
        drain = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) src[i].delete();
        apply();
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic run_trace(input int n);
        for (int i = 0; i < n; i++) cyc();
        trace_en = 1'b0;
    endtask

    task automatic start_trace();
        trace    = '0;
        trace_en = 1'b1;
        apply();
    endtask

    logic [3:0] v5 [9] = '{4'hA, 4'h5, 4'hC, 4'h3, 4'hF, 4'h0, 4'h9, 4'h6, 4'hE};

    initial begin
        #(50 * 3000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset mid-burst, then req0 beats req2 on release
        reset_dut();
        load(1, 4'h6, 1'b1); load(1, 4'h7, 1'b1); load(1, 4'h8, 1'b0); load(1, 4'h9, 1'b0);
        apply();
        cyc(); cyc(); cyc();
        check("t1_midburst_grant_id", 32'(grant_id), 1);
        check("t1_midburst_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("t1_rst_ready", 32'(req_ready), 0);
        check("t1_rst_wr_en", 32'(fifo_wr_en), 0);
        check("t1_rst_wr_data", 32'(fifo_wr_data), 0);
        check("t1_rst_grant_id", 32'(grant_id), 0);
        check("t1_rst_busy", 32'(busy), 0);
        src[1].delete();
        load(0, 4'hA, 1'b1); load(0, 4'hB, 1'b1); load(2, 4'hC, 1'b1);
        apply();
        cyc();
        #1;
        check("t1_rst_hold_ready", 32'(req_ready), 0);
        reset = 1'b1;
        cyc();
        #1;
        check("t1_first_grant_id", 32'(grant_id), 0);
        check("t1_first_busy", 32'(busy), 1);
        check("t1_first_ready", 32'(req_ready), 32'h1);
        for (int i = 0; i < 10; i++) cyc();
        check("t1_drained", exp_q.size(), 0);

        // 2: round robin with all four valid
        reset_dut();
        for (int i = 1; i <= 4; i++) load(0, 4'(i), 1'b1);
        load(1, 4'h9, 1'b1); load(1, 4'hA, 1'b1); load(1, 4'hB, 1'b1); load(1, 4'hC, 1'b1);
        load(2, 4'hD, 1'b1); load(2, 4'hE, 1'b1); load(2, 4'hF, 1'b1); load(2, 4'h0, 1'b1);
        load(3, 4'h1, 1'b1); load(3, 4'h3, 1'b1); load(3, 4'h5, 1'b1); load(3, 4'h7, 1'b1);
        for (int i = 5; i <= 8; i++) load(0, 4'(i), 1'b1);
        start_trace();
        run_trace(26);
        check("t2_trace", trace, 32'b0_1111_0_1111_0_1111_0_1111_0_1111_0);
        check("t2_drained", exp_q.size(), 0);

        // 3: backpressure stall inside a req1 burst
        reset_dut();
        for (int i = 1; i <= 6; i++) load(1, 4'(i), 1'b1);
        start_trace();
        cyc(); cyc(); cyc();
        force_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("t3_stall_wr_en", 32'(fifo_wr_en), 0);
            check("t3_stall_ready", 32'(req_ready), 0);
            check("t3_stall_busy", 32'(busy), 1);
            cyc();
        end
        force_full = 1'b0;
        run_trace(7);
        check("t3_trace", trace, 32'b0110001101100);
        check("t3_drained", exp_q.size(), 0);

        // 4: early release by req2 hands over to req3 ahead of req0
        reset_dut();
        load(2, 4'h2, 1'b1); load(2, 4'h4, 1'b1);
        load(3, 4'h8, 1'b1); load(3, 4'h9, 1'b1);
        load(0, 4'h1, 1'b1);
        void'(src[0].pop_front());
        start_trace();
        cyc(); cyc(); cyc();
        src[0].push_back(4'h1);
        apply();
        cyc();
        #1;
        check("t4_idle_grant_id", 32'(grant_id), 2);
        check("t4_idle_busy", 32'(busy), 0);
        cyc();
        #1;
        check("t4_next_grant_id", 32'(grant_id), 3);
        run_trace(7);
        check("t4_trace", trace, 32'b011001100100);
        check("t4_drained", exp_q.size(), 0);

        // 5: fill the fifo, stall, free one slot, read back in order
        reset_dut();
        drain  = 1'b0;
        rd_chk = 1'b1;
        for (int i = 0; i < 9; i++) begin
            load(0, v5[i], 1'b1);
            rd_q.push_back(v5[i]);
        end
        start_trace();
        for (int i = 0; i < 11; i++) cyc();
        for (int s = 0; s < 2; s++) begin
            #1;
            check("t5_full_wr_en", 32'(fifo_wr_en), 0);
            check("t5_full_ready", 32'(req_ready), 0);
            check("t5_full_busy", 32'(busy), 1);
            cyc();
        end
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        run_trace(2);
        check("t5_trace", trace, 32'b0111101111000010);
        drain = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        check("t5_write_drained", exp_q.size(), 0);
        check("t5_read_drained", rd_q.size(), 0);
        rd_chk = 1'b0;

        // 6: lone requester re-granted after each bubble
        reset_dut();
        for (int i = 0; i < 12; i++) load(3, 4'(i), 1'b1);
        start_trace();
        run_trace(16);
        check("t6_trace", trace, 32'b0111101111011110);
        check("t6_grant_id", 32'(grant_id), 3);
        check("t6_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
